// File: rtl/traffic_pkg.sv
// Shared types, default timing and helpers for the N-lane traffic controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    AMBER   = 2'd1,
    ALL_RED = 2'd2
  } light_state_t;

  localparam int DEF_NUM_LANES     = 4;
  localparam int DEF_TICKS_PER_SEC = 6;
  localparam int DEF_MIN_GREEN_S   = 10;
  localparam int DEF_MAX_GREEN_S   = 60;
  localparam int DEF_AMBER_S       = 5;
  localparam int DEF_ALL_RED_S     = 2;

  // Index width for n items, never below one bit.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_lane_arbiter.sv
// Combinational round-robin pick: first pending lane after active_lane, wrapping.
module rr_lane_arbiter
  import traffic_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES
) (
  input  logic [NUM_LANES-1:0]         pending,
  input  logic [lane_w(NUM_LANES)-1:0] active_lane,
  output logic [lane_w(NUM_LANES)-1:0] grant,
  output logic                         grant_valid
);

  localparam int LW = lane_w(NUM_LANES);

  int idx;

  // Walk the rotation backwards so the nearest successor is the last write.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      idx = (int'(active_lane) + k) % NUM_LANES;
      if (|(pending & (NUM_LANES'(1) << idx))) begin
        grant       = LW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_nway.sv
// Actuated N-lane traffic-light controller with second prescaler, min/max green,
// amber and all-red clearance, and round-robin service of pending lanes.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   GREEN   | active_lane green, others red; gap-out or max-out to AMBER
//   AMBER   | active_lane amber for AMBER_S seconds
//   ALL_RED | every lane red for ALL_RED_S seconds, then next_lane goes green
module traffic_ctrl_nway
  import traffic_pkg::*;
#(
  parameter int NUM_LANES     = DEF_NUM_LANES,
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int MIN_GREEN_S   = DEF_MIN_GREEN_S,
  parameter int MAX_GREEN_S   = DEF_MAX_GREEN_S,
  parameter int AMBER_S       = DEF_AMBER_S,
  parameter int ALL_RED_S     = DEF_ALL_RED_S
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_LANES-1:0]             lane_req,
  output logic [NUM_LANES-1:0]             red_light,
  output logic [NUM_LANES-1:0]             amber_light,
  output logic [NUM_LANES-1:0]             green_light,
  output logic [lane_w(NUM_LANES)-1:0]     active_lane,
  output logic [7:0]                       sec_counter_val,
  output logic [lane_w(TICKS_PER_SEC)-1:0] mili_sec_counter_val
);

  localparam int LW = lane_w(NUM_LANES);
  localparam int TW = lane_w(TICKS_PER_SEC);

  light_state_t          state, state_nxt;
  logic [LW-1:0]         next_lane;
  logic [NUM_LANES-1:0]  pending, pending_nxt;
  logic [NUM_LANES-1:0]  active_mask;
  logic [LW-1:0]         grant;
  logic                  grant_valid;
  logic                  sec_tick;
  logic [7:0]            sec_inc;
  logic                  req_active;
  logic                  latch_next;
  logic                  enter_green;

  rr_lane_arbiter #(
    .NUM_LANES (NUM_LANES)
  ) u_arb (
    .pending     (pending),
    .active_lane (active_lane),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign active_mask = NUM_LANES'(1) << active_lane;
  assign req_active  = |(lane_req & active_mask);
  assign sec_tick    = (mili_sec_counter_val == TW'(TICKS_PER_SEC - 1));
  assign sec_inc     = (sec_counter_val >= 8'(MAX_GREEN_S)) ? 8'(MAX_GREEN_S)
                                                            : sec_counter_val + 8'd1;

  always_comb begin
    state_nxt   = state;
    latch_next  = 1'b0;
    enter_green = 1'b0;
    case (state)
      GREEN: begin
        if (sec_tick && grant_valid &&
            ((sec_inc >= 8'(MIN_GREEN_S) && !req_active) ||
             (sec_inc >= 8'(MAX_GREEN_S)))) begin
          state_nxt  = AMBER;
          latch_next = 1'b1;
        end
      end
      AMBER: begin
        if (sec_tick && sec_inc == 8'(AMBER_S)) state_nxt = ALL_RED;
      end
      ALL_RED: begin
        if (sec_tick && sec_inc == 8'(ALL_RED_S)) begin
          state_nxt   = GREEN;
          enter_green = 1'b1;
        end
      end
      default: state_nxt = GREEN;
    endcase
  end

  // Clearing the entering lane overrides a same-cycle request from it.
  always_comb begin
    pending_nxt = pending | (lane_req & ~active_mask);
    if (enter_green) pending_nxt = pending_nxt & ~(NUM_LANES'(1) << next_lane);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                <= GREEN;
      active_lane          <= '0;
      next_lane            <= '0;
      pending              <= '0;
      sec_counter_val      <= '0;
      mili_sec_counter_val <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (latch_next)  next_lane   <= grant;
      if (enter_green) active_lane <= next_lane;
      if (state_nxt != state) begin
        sec_counter_val      <= '0;
        mili_sec_counter_val <= '0;
      end else if (sec_tick) begin
        sec_counter_val      <= sec_inc;
        mili_sec_counter_val <= '0;
      end else begin
        mili_sec_counter_val <= mili_sec_counter_val + TW'(1);
      end
    end
  end

  always_comb begin
    green_light = '0;
    amber_light = '0;
    red_light   = '1;
    case (state)
      GREEN: begin
        green_light = active_mask;
        red_light   = ~active_mask;
      end
      AMBER: begin
        amber_light = active_mask;
        red_light   = ~active_mask;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Table-driven bench for traffic_ctrl_nway using short timing parameters.
module tb_traffic_ctrl_nway;

  localparam int NL = 4;

  logic          clk;
  logic          rstn;
  logic [NL-1:0] lane_req;
  logic [NL-1:0] red_light, amber_light, green_light;
  logic [1:0]    active_lane;
  logic [7:0]    sec_counter_val;
  logic [1:0]    mili_sec_counter_val;

  int errors = 0;
  int checks = 0;

  traffic_ctrl_nway #(
    .NUM_LANES     (NL),
    .TICKS_PER_SEC (4),
    .MIN_GREEN_S   (3),
    .MAX_GREEN_S   (6),
    .AMBER_S       (2),
    .ALL_RED_S     (1)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .lane_req             (lane_req),
    .red_light            (red_light),
    .amber_light          (amber_light),
    .green_light          (green_light),
    .active_lane          (active_lane),
    .sec_counter_val      (sec_counter_val),
    .mili_sec_counter_val (mili_sec_counter_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ncyc;
    logic [3:0] req;
    logic [3:0] g;
    logic [3:0] a;
    logic [3:0] r;
    logic [1:0] act;
    logic [7:0] sec;
    logic [1:0] ms;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic [3:0] req, input logic [3:0] g,
                     input logic [3:0] a, input logic [3:0] r, input logic [1:0] act,
                     input int sec, input int ms);
    vec_t v;
    v.ncyc = n; v.req = req; v.g = g; v.a = a; v.r = r; v.act = act;
    v.sec = 8'(sec); v.ms = 2'(ms);
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string name, input logic [3:0] g, input logic [3:0] a,
                           input logic [3:0] r, input logic [1:0] act,
                           input logic [7:0] sec, input logic [1:0] ms);
    logic [23:0] got, exp;
    got = {green_light, amber_light, red_light, active_lane, sec_counter_val, mili_sec_counter_val};
    exp = {g, a, r, act, sec, ms};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got g=%b a=%b r=%b lane=%0d sec=%0d ms=%0d, want g=%b a=%b r=%b lane=%0d sec=%0d ms=%0d",
               name, green_light, amber_light, red_light, active_lane, sec_counter_val,
               mili_sec_counter_val, g, a, r, act, sec, ms);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      lane_req = tbl[i].req;
      repeat (tbl[i].ncyc) step();
      check_out($sformatf("row%0d", i), tbl[i].g, tbl[i].a, tbl[i].r, tbl[i].act,
                tbl[i].sec, tbl[i].ms);
    end
  endtask

  // Drop rstn mid-cycle, verify immediate effect, hold 3 cycles, release on a negedge.
  task automatic do_reset(input string name);
    @(posedge clk);
    #2;
    rstn     = 1'b0;
    lane_req = '0;
    #1;
    check_out({name, "_async"}, 4'b0001, 4'b0000, 4'b1110, 2'd0, 8'd0, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out({name, "_hold"}, 4'b0001, 4'b0000, 4'b1110, 2'd0, 8'd0, 2'd0);
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      checks++;
      if (((green_light & amber_light) | (green_light & red_light) | (amber_light & red_light)) != 4'b0 ||
          (green_light | amber_light | red_light) != 4'b1111 ||
          $countones(~red_light) > 1 || sec_counter_val > 8'd6 || mili_sec_counter_val > 2'd3) begin
        errors++;
        $display("FAIL invariant @%0t: g=%b a=%b r=%b sec=%0d ms=%0d, want one lamp per lane, <=1 non-red, sec<=6, ms<=3",
                 $time, green_light, amber_light, red_light, sec_counter_val, mili_sec_counter_val);
      end
    end
  end

  initial begin
    // Segment A (0..17): gap-out to lane 2, idle saturation, round-robin 3 then 1.
    add(0,  4'b0000, 4'b0001, 4'b0000, 4'b1110, 2'd0, 0, 0);
    add(2,  4'b0000, 4'b0001, 4'b0000, 4'b1110, 2'd0, 0, 2);
    add(1,  4'b0100, 4'b0001, 4'b0000, 4'b1110, 2'd0, 0, 3);
    add(8,  4'b0000, 4'b0001, 4'b0000, 4'b1110, 2'd0, 2, 3);
    add(1,  4'b0000, 4'b0000, 4'b0001, 4'b1110, 2'd0, 0, 0);
    add(7,  4'b0000, 4'b0000, 4'b0001, 4'b1110, 2'd0, 1, 3);
    add(1,  4'b0000, 4'b0000, 4'b0000, 4'b1111, 2'd0, 0, 0);
    add(3,  4'b0000, 4'b0000, 4'b0000, 4'b1111, 2'd0, 0, 3);
    add(1,  4'b0000, 4'b0100, 4'b0000, 4'b1011, 2'd2, 0, 0);
    add(40, 4'b0000, 4'b0100, 4'b0000, 4'b1011, 2'd2, 6, 0);
    add(1,  4'b1010, 4'b0100, 4'b0000, 4'b1011, 2'd2, 6, 1);
    add(3,  4'b0000, 4'b0000, 4'b0100, 4'b1011, 2'd2, 0, 0);
    add(8,  4'b0000, 4'b0000, 4'b0000, 4'b1111, 2'd2, 0, 0);
    add(4,  4'b0000, 4'b1000, 4'b0000, 4'b0111, 2'd3, 0, 0);
    add(12, 4'b0000, 4'b0000, 4'b1000, 4'b0111, 2'd3, 0, 0);
    add(8,  4'b0000, 4'b0000, 4'b0000, 4'b1111, 2'd3, 0, 0);
    add(4,  4'b0000, 4'b0010, 4'b0000, 4'b1101, 2'd1, 0, 0);
    add(40, 4'b0000, 4'b0010, 4'b0000, 4'b1101, 2'd1, 6, 0);
    // Segment B (18..22): lane 0 held, lane 1 waiting -> max-out after 24 cycles.
    add(12, 4'b0011, 4'b0001, 4'b0000, 4'b1110, 2'd0, 3, 0);
    add(11, 4'b0011, 4'b0001, 4'b0000, 4'b1110, 2'd0, 5, 3);
    add(1,  4'b0011, 4'b0000, 4'b0001, 4'b1110, 2'd0, 0, 0);
    add(8,  4'b0011, 4'b0000, 4'b0000, 4'b1111, 2'd0, 0, 0);
    add(4,  4'b0011, 4'b0010, 4'b0000, 4'b1101, 2'd1, 0, 0);
    // Segment C (23..29): reach lane 2 amber with lane 3 pending.
    add(2,  4'b0000, 4'b0001, 4'b0000, 4'b1110, 2'd0, 0, 2);
    add(1,  4'b0100, 4'b0001, 4'b0000, 4'b1110, 2'd0, 0, 3);
    add(9,  4'b0000, 4'b0000, 4'b0001, 4'b1110, 2'd0, 0, 0);
    add(12, 4'b0000, 4'b0100, 4'b0000, 4'b1011, 2'd2, 0, 0);
    add(1,  4'b1001, 4'b0100, 4'b0000, 4'b1011, 2'd2, 0, 1);
    add(11, 4'b0000, 4'b0000, 4'b0100, 4'b1011, 2'd2, 0, 0);
    add(2,  4'b0000, 4'b0000, 4'b0100, 4'b1011, 2'd2, 0, 2);
    // Segment D (30..31): after reset, timing restarts and pending is empty.
    add(5,  4'b0000, 4'b0001, 4'b0000, 4'b1110, 2'd0, 1, 1);
    add(40, 4'b0000, 4'b0001, 4'b0000, 4'b1110, 2'd0, 6, 1);

    rstn     = 1'b0;
    lane_req = '0;
    repeat (3) @(negedge clk);
    check_out("por", 4'b0001, 4'b0000, 4'b1110, 2'd0, 8'd0, 2'd0);
    rstn = 1'b1;

    run_rows(0, 17);
    do_reset("rst_lane1_green");
    run_rows(18, 22);
    do_reset("rst_maxout");
    run_rows(23, 29);
    do_reset("rst_mid_amber");
    run_rows(30, 31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_nway.md
Name: traffic_ctrl_nway

Overview:
- Parametrised N-lane actuated traffic-light controller; generalises the two-lane A/B controller to NUM_LANES approaches with per-lane vehicle sensors.
- Provides configurable second timing, minimum and maximum green, amber and all-red clearance, and round-robin service of pending requests.
- Sits between the sensor front-end, whose inputs are already synchronised to clk, and the lamp drivers. Also exports its counters for debug and monitoring.

Parameters:
- NUM_LANES, 4, number of approaches (>=2)
- TICKS_PER_SEC, 6, clk cycles per timing second (sub-second prescaler)
- MIN_GREEN_S, 10, minimum green in seconds (>=1)
- MAX_GREEN_S, 60, green-extension ceiling in seconds (>= MIN_GREEN_S, <= 255)
- AMBER_S, 5, amber duration in seconds (>=1)
- ALL_RED_S, 2, all-red clearance in seconds (>=1)

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- lane_req  in  NUM_LANES  level vehicle-present sensor per lane
- red_light  out  NUM_LANES  red lamp per lane
- amber_light  out  NUM_LANES  amber lamp per lane
- green_light  out  NUM_LANES  green lamp per lane
- active_lane  out  $clog2(NUM_LANES)  lane currently owning green/amber
- sec_counter_val  out  8  seconds elapsed in current state
- mili_sec_counter_val  out  $clog2(TICKS_PER_SEC)  sub-second tick count

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rstn): all state registers clear immediately on rstn low.
- Reset values:
  - state = GREEN, active_lane = 0.
  - green_light = 1 on lane 0 only; red_light = 1 on all other lanes; amber_light = 0.
  - counters = 0, pending = 0, next_lane = 0.
- Prescaler: mili_sec_counter_val counts 0..TICKS_PER_SEC-1 and wraps. sec_tick = (count == TICKS_PER_SEC-1).
  - On every state change, both counters reload to 0 on the transition edge.
  - Each state therefore lasts an integer number of seconds × TICKS_PER_SEC cycles.
- sec_counter_val: increments on sec_tick and saturates at MAX_GREEN_S. It never exceeds MAX_GREEN_S.
- Pending register:
  - pending[i] sets when lane_req[i]=1 and i != active_lane.
  - pending[i] is sticky until lane i enters GREEN; it clears on that edge.
  - Requests from the green lane never set pending.
- States: GREEN, AMBER, ALL_RED.
  - GREEN → AMBER at a sec_tick where the post-increment second count S satisfies either:
    - S >= MIN_GREEN_S, pending != 0, and lane_req[active_lane]=0 (gap-out); or
    - S >= MAX_GREEN_S and pending != 0 (max-out).
    On this edge, next_lane is latched from the round-robin arbiter.
  - GREEN with pending == 0: holds indefinitely; the counter saturates at MAX_GREEN_S.
  - AMBER → ALL_RED at the sec_tick where S == AMBER_S.
  - ALL_RED → GREEN at the sec_tick where S == ALL_RED_S. On this edge active_lane <= next_lane.
- Round-robin arbiter: searches pending starting at active_lane+1, wrapping modulo NUM_LANES, and takes the first set bit. Simultaneous requests are served in that rotation order.
- Lamps are decoded from registered state and active_lane, so they change on the transition edge with no glitches.
  - GREEN: green on active_lane only.
  - AMBER: amber on active_lane only.
  - ALL_RED: all lanes red.
  - Every other lane is red.
  - Invariant: exactly one lamp is on per lane, and at most one lane is non-red.
- active_lane is held through AMBER and ALL_RED.
- Reset mid-operation from any state returns to the reset values immediately. No clearance is re-run.

Decomposition:
- traffic_pkg holds:
  - typedef enum logic [1:0] {GREEN, AMBER, ALL_RED} light_state_t;
  - the default timing constants;
  - a function for the lane-index width.
- Sub-module rr_lane_arbiter (parameter NUM_LANES): purely combinational.
  - Inputs: pending, active_lane.
  - Outputs: grant index and grant_valid.
- Top module holds the prescaler, second counter, FSM, pending register and lamp decode.

Test Plan:
Test parameters: NUM_LANES=4, TICKS_PER_SEC=4, MIN_GREEN_S=3, MAX_GREEN_S=6, AMBER_S=2, ALL_RED_S=1.
- Reset: rstn=0 asynchronously mid-cycle → outputs take reset values immediately; green_light=4'b0001, red_light=4'b1110, counters 0.
- Idle: no requests for 100 cycles → lane 0 green throughout; sec_counter_val saturates at 6; mili_sec_counter_val cycles 0..3.
- Gap-out: lane_req=4'b0100 pulsed for one cycle at cycle 2 → lane 0 green 12 cycles, amber 8 cycles, all-red 4 cycles, then green_light=4'b0100 with active_lane=2 and pending[2] cleared.
- Extension/max-out: lane_req[0] held high plus lane_req[1] asserted → lane 0 green exactly 24 cycles (6 s), then amber, all-red, green on lane 1.
- Round-robin: lanes 3 and 1 request simultaneously while lane 2 green → service order is 3, then 1; lane 0 is not served.
- Reset mid-AMBER: rstn low for 3 cycles during lane 2 amber → lane 0 green and pending cleared. On release, timing restarts from 0.
- Throughout all scenarios, assertions check:
  - at most one lamp on per lane;
  - at most one non-red lane;
  - sec_counter_val <= 6;
  - mili_sec_counter_val <= 3.
